// File: rtl/btn_event_sched_pkg.sv
// Shared constants for the button event path: default button count,
// event code width and the named button indices.
package btn_pkg;

  localparam int N_BTN_DEF = 5;
  localparam int CW_DEF    = $clog2(N_BTN_DEF);

  localparam int BTN_CENTER = 0;
  localparam int BTN_UP     = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_DOWN   = 4;

endpackage

// File: rtl/btn_event_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or after index rr,
// searching upward and wrapping. The grant is one-hot or zero.
module rr_arbiter #(
  parameter  int N  = 5,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] rr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] gidx,
  output logic          gvalid
);

  // Rotating priority search starting at the round-robin pointer
  always_comb begin
    int j;
    j      = 0;
    grant  = '0;
    gidx   = '0;
    gvalid = 1'b0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        j = (int'(rr) + k) % N;
        if (!gvalid && req[j]) begin
          gvalid   = 1'b1;
          grant[j] = 1'b1;
          gidx     = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/btn_event_sched.sv
// Button event scheduler: latches debounced press pulses, serves them
// round-robin into a small event FIFO, and presents the head event to a
// consumer over a valid/ready handshake. A sticky flag records presses
// that merged into an already pending press.
module btn_event_sched
  import btn_pkg::*;
#(
  parameter  int N_BTN = N_BTN_DEF,
  parameter  int DEPTH = 4,
  localparam int CW    = (N_BTN > 1) ? $clog2(N_BTN) : 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_pulse,
  input  logic             evt_ready,
  input  logic             clr_ovf,
  output logic             evt_valid,
  output logic [CW-1:0]    evt_code,
  output logic [N_BTN-1:0] pending,
  output logic [AW:0]      fifo_count,
  output logic             ovf
);

  // Advance the round-robin pointer past the granted index, wrapping.
  function automatic logic [CW-1:0] rr_after(input logic [CW-1:0] g);
    return (g == CW'(N_BTN - 1)) ? '0 : g + 1'b1;
  endfunction

  logic [CW-1:0]    rr;
  logic [N_BTN-1:0] grant;
  logic [CW-1:0]    gidx;
  logic             gvalid;
  logic             arb_en;
  logic             push;
  logic             pop;
  logic             coalesce;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    mem [DEPTH];

  // Space check uses the registered count only; a same-cycle pop does not
  // open a slot for a push.
  assign arb_en   = (fifo_count < (AW+1)'(DEPTH));
  assign push     = gvalid;
  assign pop      = evt_valid & evt_ready;
  assign coalesce = |(btn_pulse & pending & ~grant);

  rr_arbiter #(.N(N_BTN)) u_arb (
    .req    (pending),
    .en     (arb_en),
    .rr     (rr),
    .grant  (grant),
    .gidx   (gidx),
    .gvalid (gvalid)
  );

  // Control state: pending latch, round-robin pointer, FIFO pointers/count, overflow
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      pending    <= '0;
      rr         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ovf        <= 1'b0;
    end else begin
      pending <= (pending & ~grant) | btn_pulse;
      if (gvalid) rr <= rr_after(gidx);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      if (coalesce)     ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  // Event storage: data only, never reset; the pointers decide what is live
  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= gidx;
  end

  assign evt_valid = (fifo_count != '0);
  assign evt_code  = evt_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_btn_event_sched.sv
// Directed bench for btn_event_sched: a table of per-cycle input and
// expected-output records, plus hand sequences for the grant/pulse
// collision, reset during operation and ready-while-empty.
module tb_btn_event_sched;

  logic       sysclk = 1'b0;
  logic       reset_n;
  logic [4:0] btn_pulse;
  logic       evt_ready;
  logic       clr_ovf;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic [4:0] pending;
  logic [2:0] fifo_count;
  logic       ovf;

  int n_tests = 0;
  int n_fail  = 0;

  btn_event_sched #(.N_BTN(5), .DEPTH(4)) dut (
    .sysclk     (sysclk),
    .reset_n    (reset_n),
    .btn_pulse  (btn_pulse),
    .evt_ready  (evt_ready),
    .clr_ovf    (clr_ovf),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .pending    (pending),
    .fifo_count (fifo_count),
    .ovf        (ovf)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic       rn;
    logic [4:0] btn;
    logic       rdy;
    logic       clr;
    logic [4:0] pend;
    logic       vld;
    logic [2:0] code;
    logic [2:0] cnt;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rn, input logic [4:0] btn, input logic rdy,
                              input logic clr, input logic [4:0] pend, input logic vld,
                              input logic [2:0] code, input logic [2:0] cnt, input logic o);
    vec_t v;
    v.rn = rn; v.btn = btn; v.rdy = rdy; v.clr = clr;
    v.pend = pend; v.vld = vld; v.code = code; v.cnt = cnt; v.ovf = o;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // Apply one cycle of inputs, clock it, then compare the registered results.
  task automatic step(input int idx, input vec_t v);
    reset_n   = v.rn;
    btn_pulse = v.btn;
    evt_ready = v.rdy;
    clr_ovf   = v.clr;
    @(posedge sysclk);
    #1;
    chk("pending",    idx, int'(pending),    int'(v.pend));
    chk("evt_valid",  idx, int'(evt_valid),  int'(v.vld));
    chk("fifo_count", idx, int'(fifo_count), int'(v.cnt));
    chk("ovf",        idx, int'(ovf),        int'(v.ovf));
    if (v.vld) chk("evt_code", idx, int'(evt_code), int'(v.code));
  endtask

  initial begin
    vec_t h;
    reset_n = 1'b0; btn_pulse = '0; evt_ready = 1'b0; clr_ovf = 1'b0;

    //   rn btn      rdy clr  pend     vld code cnt ovf
    // reset with all buttons pulsing
    add(0, 5'b11111, 0, 0,  5'b00000, 0, 0, 0, 0);
    add(0, 5'b11111, 0, 0,  5'b00000, 0, 0, 0, 0);
    add(0, 5'b11111, 0, 0,  5'b00000, 0, 0, 0, 0);
    // single press of button 2, then pop
    add(1, 5'b00100, 0, 0,  5'b00100, 0, 0, 0, 0);
    add(1, 5'b00000, 0, 0,  5'b00000, 1, 2, 1, 0);
    add(1, 5'b00000, 1, 0,  5'b00000, 0, 0, 0, 0);
    // press 4 to bring rr back to 0
    add(1, 5'b10000, 1, 0,  5'b10000, 0, 0, 0, 0);
    add(1, 5'b00000, 1, 0,  5'b00000, 1, 4, 1, 0);
    add(1, 5'b00000, 1, 0,  5'b00000, 0, 0, 0, 0);
    // simultaneous 0,1,4 queued in that order, then drained
    add(1, 5'b10011, 0, 0,  5'b10011, 0, 0, 0, 0);
    add(1, 5'b00000, 0, 0,  5'b10010, 1, 0, 1, 0);
    add(1, 5'b00000, 0, 0,  5'b10000, 1, 0, 2, 0);
    add(1, 5'b00000, 0, 0,  5'b00000, 1, 0, 3, 0);
    add(1, 5'b00000, 1, 0,  5'b00000, 1, 1, 2, 0);
    add(1, 5'b00000, 1, 0,  5'b00000, 1, 4, 1, 0);
    add(1, 5'b00000, 1, 0,  5'b00000, 0, 0, 0, 0);
    // 0,1 again with rr=0
    add(1, 5'b00011, 0, 0,  5'b00011, 0, 0, 0, 0);
    add(1, 5'b00000, 0, 0,  5'b00010, 1, 0, 1, 0);
    add(1, 5'b00000, 0, 0,  5'b00000, 1, 0, 2, 0);
    add(1, 5'b00000, 1, 0,  5'b00000, 1, 1, 1, 0);
    add(1, 5'b00000, 1, 0,  5'b00000, 0, 0, 0, 0);
    // rr=2: 0,1,2 serve as 2,0,1; then 0 fills the FIFO
    add(1, 5'b00111, 0, 0,  5'b00111, 0, 0, 0, 0);
    add(1, 5'b00000, 0, 0,  5'b00011, 1, 2, 1, 0);
    add(1, 5'b00000, 0, 0,  5'b00010, 1, 2, 2, 0);
    add(1, 5'b00000, 0, 0,  5'b00000, 1, 2, 3, 0);
    add(1, 5'b00001, 0, 0,  5'b00001, 1, 2, 3, 0);
    add(1, 5'b01000, 0, 0,  5'b01000, 1, 2, 4, 0);
    // full: press 3 waits, head stable while not ready
    add(1, 5'b00000, 0, 0,  5'b01000, 1, 2, 4, 0);
    add(1, 5'b00000, 0, 0,  5'b01000, 1, 2, 4, 0);
    // coalesce on button 1 while full; set beats clear; clear alone
    add(1, 5'b00010, 0, 0,  5'b01010, 1, 2, 4, 0);
    add(1, 5'b00010, 0, 0,  5'b01010, 1, 2, 4, 1);
    add(1, 5'b00010, 0, 1,  5'b01010, 1, 2, 4, 1);
    add(1, 5'b00000, 0, 1,  5'b01010, 1, 2, 4, 0);
    // pops free space one slot at a time; pending drains 1 then 3
    add(1, 5'b00000, 1, 0,  5'b01010, 1, 0, 3, 0);
    add(1, 5'b00000, 0, 0,  5'b01000, 1, 0, 4, 0);
    add(1, 5'b00000, 1, 0,  5'b01000, 1, 1, 3, 0);
    add(1, 5'b00000, 0, 0,  5'b00000, 1, 1, 4, 0);
    add(1, 5'b00000, 1, 0,  5'b00000, 1, 0, 3, 0);
    add(1, 5'b00000, 1, 0,  5'b00000, 1, 1, 2, 0);
    add(1, 5'b00000, 1, 0,  5'b00000, 1, 3, 1, 0);
    add(1, 5'b00000, 1, 0,  5'b00000, 0, 0, 0, 0);

    foreach (vecs[i]) step(i, vecs[i]);

    // Collision: button 0 pulses again in the cycle its pending bit is granted
    h.rn = 1; h.btn = 5'b00001; h.rdy = 0; h.clr = 0;
    h.pend = 5'b00001; h.vld = 0; h.code = 0; h.cnt = 0; h.ovf = 0;
    step(100, h);
    h.pend = 5'b00001; h.vld = 1; h.code = 0; h.cnt = 1;
    step(101, h);
    h.btn = 5'b00000; h.pend = 5'b00000; h.cnt = 2;
    step(102, h);
    h.rdy = 1; h.cnt = 1;
    step(103, h);

    // Reset with an event queued and pulses arriving: everything discarded
    h.rn = 0; h.btn = 5'b11111; h.rdy = 0; h.pend = 5'b00000; h.vld = 0; h.cnt = 0;
    step(110, h);
    h.rn = 1; h.btn = 5'b00000;
    step(111, h);
    step(112, h);

    // Ready while empty: no underflow
    h.rdy = 1;
    step(120, h);
    step(121, h);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_event_sched.md
Name: btn_event_sched

Overview:
Arbitration and queuing controller placed downstream of the five-button debouncer. It takes the one-cycle debounced pulses from buttons 0-4, latches each press, and serves the pending presses round-robin. Each served press is pushed into a small FIFO as an encoded event. Consumers such as menu and game FSMs pop events over a valid/ready handshake, so presses are never lost while a consumer is busy.

Parameters:
N_BTN, 5, number of button pulse inputs (code width CW = 3 for the default)
DEPTH, 4, event FIFO depth in entries (power of two, at least 2)

Ports:
sysclk  input  1  system clock; all state updates on the rising edge
reset_n  input  1  synchronous active-low reset
btn_pulse  input  N_BTN  one-cycle debounced press pulses; bit i = button i
evt_ready  input  1  consumer accepts the head event this cycle
clr_ovf  input  1  clears the sticky overflow flag
evt_valid  output  1  FIFO not empty; head event presented
evt_code  output  CW  button index of the head event (0..N_BTN-1)
pending  output  N_BTN  latched presses not yet queued
fifo_count  output  clog2(DEPTH)+1  number of queued events
ovf  output  1  sticky flag: a press was coalesced or dropped

Behaviour:
- One clock and one reset domain. Reset is synchronous and active-low: sampled only on a sysclk rising edge while reset_n=0. Reset has priority over every other event.
- Reset values:
  - pending=0, fifo_count=0, evt_valid=0, evt_code=0, ovf=0.
  - Round-robin pointer rr=0.
  - FIFO read and write pointers = 0.
- Pending latch, per bit i, next value = (pending[i] & ~grant[i]) | btn_pulse[i].
  - A new pulse in the same cycle the bit is granted leaves the bit set, so the second press is counted.
- Coalesce: if btn_pulse[i]=1 while pending[i]=1 and grant[i]=0, the press merges into the existing one, and ovf is set at that edge.
- Arbiter (combinational, from registered pending and rr):
  - Enabled only when fifo_count < DEPTH. A pop in the same cycle does not free space for a push.
  - Grants the first set pending bit at or after index rr, searching upward and wrapping from N_BTN-1 to 0.
  - grant is one-hot or zero.
  - On a grant of index g, rr <= g+1 mod N_BTN. With no grant, rr holds.
- Push: on grant of index g, g is written at the write pointer and the write pointer increments, wrapping at DEPTH.
- Pop: when evt_valid & evt_ready, the read pointer increments.
  - evt_ready while empty has no effect and no underflow.
- fifo_count: +1 on push only, -1 on pop only, unchanged when both occur.
- Outputs:
  - evt_valid = (fifo_count != 0), driven from registered state.
  - evt_code = mem[rd_ptr]. Its value is don't-care while evt_valid=0.
  - evt_code and evt_valid hold stable while evt_valid=1 and evt_ready=0.
- Latency:
  - A pulse sampled at edge E0 sets pending after E0.
  - If the FIFO has space it is granted in the following cycle and written at E1.
  - With an empty FIFO, evt_valid rises after E1: two cycles from pulse to event.
- FIFO full: pending bits keep accumulating, and they drain in round-robin order once a pop frees space. ovf is set only by coalesce.
- ovf: set has priority over clr_ovf in the same cycle. Otherwise clr_ovf clears it.
- Reset mid-operation: pending presses and queued events are discarded. No event is emitted from pre-reset state.
- Simultaneous pulses on several buttons in one cycle:
  - All are latched.
  - They are served one per cycle in rr order, while space remains.

Decomposition:
- Shared package btn_pkg holds:
  - N_BTN_DEF=5 and the code width constant.
  - Button index localparams (BTN_CENTER=0 ... BTN_DOWN=4).
- One sub-module, rr_arbiter (pending + rr -> one-hot grant + encoded index), parameterised by N, reusable elsewhere.
- FIFO storage stays inline.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with btn_pulse=5'b11111 -> after release, pending=0, evt_valid=0, fifo_count=0, ovf=0.
- Single press: btn_pulse=5'b00100 for 1 cycle with evt_ready=0 -> pending[2]=1 after E0, evt_valid=1 with evt_code=2 after E1, fifo_count=1. evt_ready=1 for one cycle -> fifo_count=0, evt_valid=0.
- Simultaneous presses and round-robin: with rr=0, btn_pulse=5'b10011 in one cycle and evt_ready=0 -> events queued in order 0, 1, 4, and rr=0 afterward. Next btn_pulse=5'b00011 -> order 0, 1.
- Full FIFO: 4 events queued with evt_ready=0, then btn_pulse=5'b01000 -> pending[3] holds, fifo_count stays 4. A single pop lets code 3 be written on a later cycle, and fifo_count returns to 4.
- Coalesce and overflow: with FIFO full and pending[1]=1, pulse bit 1 again -> ovf=1 and pending[1] still 1. clr_ovf=1 together with a new coalescing pulse -> ovf stays 1. clr_ovf alone -> ovf=0.
- Grant/pulse collision: pending[0]=1 is granted in the same cycle btn_pulse[0]=1 -> two code-0 events are eventually queued, and ovf remains 0.
